melody_sequencer: RTL and testbench

Plays a melody stored in a synchronous note ROM. It steps through the ROM one entry at a time and drives the scale/hl selection into the divider table. It also gates the tone generator through note_en. It sits between the user controls (buttons/switches) and the divider-table/tone-generator datapath, and is the only block that changes scale and hl.

---
 rtl/music_pkg.sv | 36 +++
 rtl/beat_timer.sv | 29 ++
 rtl/melody_sequencer.sv | 159 +++++++++++++++
 tb/tb_melody_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/music_pkg.sv
// Shared definitions for the melody sequencer: note ROM word layout, scale limits,
// FSM state encoding and the duration decode helper.
package music_pkg;

    localparam int NOTE_W   = 13;
    localparam int END_BIT  = 12;
    localparam int REST_BIT = 11;
    localparam int HL_BIT   = 10;
    localparam int SCALE_HI = 9;
    localparam int SCALE_LO = 4;
    localparam int DUR_HI   = 3;
    localparam int DUR_LO   = 0;

    localparam int SCALE_W  = SCALE_HI - SCALE_LO + 1;
    localparam int DUR_W    = DUR_HI - DUR_LO + 1;
    localparam int UNIT_W   = 5;
    localparam int TIMER_W  = 24;

    localparam int NUM_SCALES     = 60;
    localparam int MAX_SCALE      = NUM_SCALES - 1;
    localparam int DUR_ZERO_UNITS = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_PLAY,
        S_GAP
    } state_t;

    // A zero duration field encodes the longest note rather than a silent one.
    function automatic logic [UNIT_W-1:0] dur_units(input logic [DUR_W-1:0] dur);
        return (dur == '0) ? UNIT_W'(DUR_ZERO_UNITS) : {1'b0, dur};
    endfunction

endpackage

// File: rtl/beat_timer.sv
// Reloadable beat down-counter; strobes expire when an enabled cycle sees terminal count 0.
module beat_timer
    import music_pkg::*;
#(
    parameter int unsigned BEAT_CYCLES = 12500000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               load,
    output logic [TIMER_W-1:0] count,
    output logic               expire
);

    localparam logic [TIMER_W-1:0] RELOAD = TIMER_W'(BEAT_CYCLES - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= RELOAD;
        end else if (en) begin
            count <= (count == '0) ? RELOAD : count - TIMER_W'(1);
        end
    end

    assign expire = en && (count == '0);

endmodule

// File: rtl/melody_sequencer.sv
// Steps through the note ROM, driving scale/hl to the divider table and gating the
// tone generator; all outputs are registered.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   S_IDLE   | stopped, waiting for start
//   S_FETCH  | ROM address presented, waiting one cycle for data
//   S_DECODE | ROM word sampled: end marker handling or note setup
//   S_PLAY   | note sounding, beat/unit counters running
//   S_GAP    | silent articulation tail before the next fetch
module melody_sequencer
    import music_pkg::*;
#(
    parameter int unsigned BEAT_CYCLES = 12500000,
    parameter int unsigned GAP_CYCLES  = 1000000,
    parameter int unsigned ADDR_W      = 8
) (
    input  logic               clk,
    input  logic               reset_,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic               loop_en,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [NOTE_W-1:0]  rom_data,
    output logic [SCALE_W-1:0] scale,
    output logic               hl,
    output logic               note_en,
    output logic               busy,
    output logic               done
);

    state_t state, state_nxt;

    logic [UNIT_W-1:0]  units, units_nxt;
    logic               note_on, note_on_nxt;
    logic [ADDR_W-1:0]  addr_nxt;
    logic [SCALE_W-1:0] scale_nxt;
    logic               hl_nxt, done_nxt;

    logic [TIMER_W-1:0] tmr_count;
    logic               tmr_expire, tmr_en, tmr_load;

    logic [SCALE_W-1:0] note_scale;
    logic [DUR_W-1:0]   note_dur;
    logic               scale_ok, last_unit, gap_hit;

    assign note_scale = rom_data[SCALE_HI:SCALE_LO];
    assign note_dur   = rom_data[DUR_HI:DUR_LO];
    assign scale_ok   = note_scale <= SCALE_W'(MAX_SCALE);
    assign last_unit  = units == UNIT_W'(1);
    assign gap_hit    = tmr_count == TIMER_W'(GAP_CYCLES);
    assign tmr_en     = !pause && (state == S_PLAY || state == S_GAP);

    beat_timer #(
        .BEAT_CYCLES(BEAT_CYCLES)
    ) u_beat_timer (
        .clk   (clk),
        .rst   (reset_),
        .en    (tmr_en),
        .load  (tmr_load),
        .count (tmr_count),
        .expire(tmr_expire)
    );

    always_ff @(posedge clk or posedge reset_) begin
        if (reset_) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (stop) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (start) state_nxt = S_FETCH;
                S_FETCH:  state_nxt = S_DECODE;
                S_DECODE: begin
                    if (rom_data[END_BIT]) state_nxt = loop_en ? S_FETCH : S_IDLE;
                    else                   state_nxt = S_PLAY;
                end
                S_PLAY:   if (!pause && last_unit && gap_hit) state_nxt = S_GAP;
                S_GAP:    if (tmr_expire) state_nxt = S_FETCH;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        addr_nxt    = rom_addr;
        scale_nxt   = scale;
        hl_nxt      = hl;
        note_on_nxt = note_on;
        units_nxt   = units;
        done_nxt    = 1'b0;
        tmr_load    = 1'b0;
        if (stop) begin
            addr_nxt    = '0;
            note_on_nxt = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) addr_nxt = '0;
                    note_on_nxt = 1'b0;
                end
                S_DECODE: begin
                    if (rom_data[END_BIT]) begin
                        note_on_nxt = 1'b0;
                        if (loop_en) addr_nxt = '0;
                        else         done_nxt = 1'b1;
                    end else begin
                        units_nxt   = dur_units(note_dur);
                        tmr_load    = 1'b1;
                        hl_nxt      = rom_data[HL_BIT];
                        // Out-of-range scales play as a rest and leave the divider untouched.
                        if (scale_ok) scale_nxt = note_scale;
                        note_on_nxt = scale_ok && !rom_data[REST_BIT];
                    end
                end
                S_PLAY: begin
                    if (!pause) begin
                        if (last_unit && gap_hit) note_on_nxt = 1'b0;
                        else if (tmr_expire)      units_nxt = units - UNIT_W'(1);
                    end
                end
                S_GAP: begin
                    if (tmr_expire) addr_nxt = rom_addr + ADDR_W'(1);
                end
                default: begin
                    note_on_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset_) begin
        if (reset_) begin
            rom_addr <= '0;
            scale    <= '0;
            hl       <= 1'b0;
            note_on  <= 1'b0;
            note_en  <= 1'b0;
            units    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            rom_addr <= addr_nxt;
            scale    <= scale_nxt;
            hl       <= hl_nxt;
            note_on  <= note_on_nxt;
            note_en  <= note_on_nxt && !pause;
            units    <= units_nxt;
            busy     <= state_nxt != S_IDLE;
            done     <= done_nxt;
        end
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with a short beat (10 cycles) and gap (2 cycles).
module tb_melody_sequencer;

    localparam int BEAT = 10;
    localparam int GAP  = 2;
    localparam int AW   = 8;

    logic          clk = 1'b0;
    logic          reset_ = 1'b0;
    logic          start = 1'b0, stop = 1'b0, pause = 1'b0, loop_en = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [12:0]   rom_data = '0;
    logic [5:0]    scale;
    logic          hl, note_en, busy, done;

    logic [12:0]   rom [0:255];

    int passed = 0;
    int total  = 0;

    // Per-window measurements.
    int m_rise, m_len, m_high, m_done, m_ndone, m_addr1, m_last, m_plow, m_mid_scale;
    int m_fin_addr, m_fin_scale, m_fin_hl, m_fin_busy;

    typedef struct {
        logic [12:0] w0, w1, w2;
        logic        loop;
        int          win;
        int          rise, len, high, done_c, ndone, addr1;
        int          fin_addr, fin_scale, fin_hl, fin_busy;
    } vec_t;

    vec_t vecs[5];

    melody_sequencer #(
        .BEAT_CYCLES(BEAT),
        .GAP_CYCLES (GAP),
        .ADDR_W     (AW)
    ) dut (
        .clk     (clk),
        .reset_  (reset_),
        .start   (start),
        .stop    (stop),
        .pause   (pause),
        .loop_en (loop_en),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .scale   (scale),
        .hl      (hl),
        .note_en (note_en),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    function automatic logic [12:0] nw(input logic e, input logic r, input logic h,
                                       input int s, input int d);
        logic [5:0] s6;
        logic [3:0] d4;
        s6 = 6'(s);
        d4 = 4'(d);
        return {e, r, h, s6, d4};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    endtask

    task automatic do_reset();
        start = 0; stop = 0; pause = 0; loop_en = 0;
        reset_ = 1;
        tick();
        tick();
        reset_ = 0;
        tick();
    endtask

    task automatic load_rom(input logic [12:0] w0, input logic [12:0] w1, input logic [12:0] w2);
        for (int i = 0; i < 256; i++) rom[i] = 13'h1000;
        rom[0] = w0;
        rom[1] = w1;
        rom[2] = w2;
    endtask

    // Cycle 0 is the cycle in which start is high.
    task automatic run_window(input int n, input int p_lo, input int p_hi, input int s2);
        int run_st;
        run_st = 0;
        m_rise = -1; m_len = 0; m_high = 0; m_done = -1; m_ndone = 0;
        m_addr1 = -1; m_last = -1; m_plow = 0; m_mid_scale = -1;
        for (int c = 0; c < n; c++) begin
            start = (c == 0) || (c == s2);
            pause = (c >= p_lo) && (c <= p_hi);
            if (note_en) begin
                m_high++;
                m_last = c;
                if (run_st == 0) begin m_rise = c; run_st = 1; end
                if (run_st == 1) m_len++;
            end else if (run_st == 1) begin
                run_st = 2;
            end
            if (done) begin
                m_ndone++;
                if (m_done < 0) m_done = c;
            end
            if (m_addr1 < 0 && rom_addr == 8'd1) m_addr1 = c;
            if (p_lo >= 0 && c > p_lo && c <= p_hi + 1 && !note_en) m_plow++;
            if (c == p_lo + 2) m_mid_scale = int'(scale);
            if (c == n - 1) begin
                m_fin_addr  = int'(rom_addr);
                m_fin_scale = int'(scale);
                m_fin_hl    = int'(hl);
                m_fin_busy  = int'(busy);
            end
            tick();
        end
        start = 0;
        pause = 0;
    endtask

    initial begin
        //        w0                     w1                     w2           loop win rise len high done nd a1 addr sc hl busy
        vecs[0] = '{nw(0,0,0,24,2),      13'h1000,              13'h1000,    0,  40,  3, 18, 18, 25, 1, 23, 1, 24, 0, 0};
        vecs[1] = '{nw(0,1,0,5,1),       nw(0,0,1,59,0),        13'h1000,    0, 200, 15,158,158,177, 1, 13, 2, 59, 1, 0};
        vecs[2] = '{nw(0,0,0,10,1),      nw(0,0,0,61,1),        13'h1000,    0,  40,  3,  8,  8, 27, 1, 13, 2, 10, 0, 0};
        vecs[3] = '{nw(0,0,0,3,1),       13'h1000,              13'h1000,    1,  40,  3,  8, 24, -1, 0, 13, 0,  3, 0, 1};
        vecs[4] = '{nw(0,0,1,0,3),       13'h1000,              13'h1000,    0,  40,  3, 28, 28, 35, 1, 33, 1,  0, 1, 0};

        load_rom(13'h1000, 13'h1000, 13'h1000);
        do_reset();
        chk("reset_rom_addr", int'(rom_addr), 0);
        chk("reset_scale",    int'(scale),    0);
        chk("reset_hl",       int'(hl),       0);
        chk("reset_note_en",  int'(note_en),  0);
        chk("reset_busy",     int'(busy),     0);
        chk("reset_done",     int'(done),     0);

        for (int v = 0; v < 5; v++) begin
            load_rom(vecs[v].w0, vecs[v].w1, vecs[v].w2);
            do_reset();
            loop_en = vecs[v].loop;
            run_window(vecs[v].win, -1, -1, -1);
            loop_en = 0;
            chk($sformatf("v%0d_rise", v),      m_rise,      vecs[v].rise);
            chk($sformatf("v%0d_len", v),       m_len,       vecs[v].len);
            chk($sformatf("v%0d_high", v),      m_high,      vecs[v].high);
            chk($sformatf("v%0d_done_cyc", v),  m_done,      vecs[v].done_c);
            chk($sformatf("v%0d_done_cnt", v),  m_ndone,     vecs[v].ndone);
            chk($sformatf("v%0d_addr1_cyc", v), m_addr1,     vecs[v].addr1);
            chk($sformatf("v%0d_fin_addr", v),  m_fin_addr,  vecs[v].fin_addr);
            chk($sformatf("v%0d_fin_scale", v), m_fin_scale, vecs[v].fin_scale);
            chk($sformatf("v%0d_fin_hl", v),    m_fin_hl,    vecs[v].fin_hl);
            chk($sformatf("v%0d_fin_busy", v),  m_fin_busy,  vecs[v].fin_busy);
        end

        // Pause for cycles 6..10 in the middle of a 2-unit note.
        load_rom(nw(0,0,0,24,2), 13'h1000, 13'h1000);
        do_reset();
        run_window(40, 6, 10, -1);
        chk("pause_rise",      m_rise,      3);
        chk("pause_first_len", m_len,       4);
        chk("pause_low_cnt",   m_plow,      5);
        chk("pause_high_tot",  m_high,      18);
        chk("pause_last_high", m_last,      25);
        chk("pause_done_cyc",  m_done,      30);
        chk("pause_mid_scale", m_mid_scale, 24);

        // Looping melody, an ignored start while busy, then stop and start together.
        load_rom(nw(0,0,0,3,1), 13'h1000, 13'h1000);
        do_reset();
        loop_en = 1;
        run_window(20, -1, -1, 5);
        chk("loop_rise",      m_rise,  3);
        chk("loop_len",       m_len,   8);
        chk("loop_addr1_cyc", m_addr1, 13);
        chk("loop_note_on",   int'(note_en), 1);
        stop = 1;
        start = 1;
        tick();
        stop = 0;
        start = 0;
        chk("stop_busy",     int'(busy),     0);
        chk("stop_note_en",  int'(note_en),  0);
        chk("stop_rom_addr", int'(rom_addr), 0);
        chk("stop_done",     int'(done),     0);
        chk("stop_scale",    int'(scale),    3);
        repeat (5) tick();
        chk("stop_stay_busy", int'(busy),    0);
        chk("stop_stay_note", int'(note_en), 0);
        loop_en = 0;

        // Asynchronous reset while a note is playing.
        load_rom(nw(0,0,1,24,2), 13'h1000, 13'h1000);
        do_reset();
        run_window(9, -1, -1, -1);
        chk("areset_pre_note", int'(note_en), 1);
        #3 reset_ = 1;
        #1;
        chk("areset_note_en", int'(note_en), 0);
        chk("areset_busy",    int'(busy),    0);
        chk("areset_scale",   int'(scale),   0);
        chk("areset_hl",      int'(hl),      0);
        @(negedge clk);
        reset_ = 0;
        tick();
        run_window(40, -1, -1, -1);
        chk("areset_rise",      m_rise,  3);
        chk("areset_len",       m_len,   18);
        chk("areset_addr1_cyc", m_addr1, 23);
        chk("areset_done_cyc",  m_done,  25);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
